// File: rtl/moore_pkg.sv
// rtl/moore_pkg.sv - shared types, defaults and parity helper for the bit serializer
// Optional feature macro: MOORE_SER_PARITY_EN (adds the PARITY state).
package moore_pkg;

    localparam int DEFAULT_WIDTH      = 8;
    localparam int DEFAULT_GAP_CYCLES = 1;
    localparam int MAX_WIDTH          = 16;

    // Explicit encodings keep S_GAP stable whether or not S_PARITY exists.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
`ifdef MOORE_SER_PARITY_EN
        S_PARITY = 2'd2,
`endif
        S_GAP    = 2'd3
    } ser_state_t;

    // Even parity over a zero-extended word; unused upper bits do not affect it.
    function automatic logic even_parity(input logic [MAX_WIDTH-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/moore_ser_hold.sv
// rtl/moore_ser_hold.sv - one-entry holding register with full flag and registered ready
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   i_push, i_data  : store a word (only issued while o_ready=1)
//   i_pop           : the shifter takes the held word this cycle
//   o_data, o_full  : held word and its valid flag
//   o_full_next     : full flag value after this edge (used for registered busy)
//   o_ready         : registered NOT full
module moore_ser_hold
    import moore_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_full_next,
    output logic             o_ready
);

    logic [WIDTH-1:0] r_data;
    logic             r_full;
    logic             r_ready;
    logic             w_full_next;

    // Push and pop never coincide: push needs ready, which is low while full.
    assign w_full_next = i_push | (r_full & ~i_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data  <= '0;
            r_full  <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            r_full  <= w_full_next;
            r_ready <= ~w_full_next;
            if (i_push) begin
                r_data <= i_data;
            end
        end
    end

    assign o_data      = r_data;
    assign o_full      = r_full;
    assign o_full_next = w_full_next;
    assign o_ready     = r_ready;

endmodule

// File: rtl/moore_bit_serializer.sv
// rtl/moore_bit_serializer.sv - LSB-first word serializer feeding a Moore sequence detector
// Optional feature macro: MOORE_SER_PARITY_EN (even parity bit after each word).
// Ports:
//   clk, reset             : clock, synchronous active-high reset
//   data_in, load_valid    : parallel word and its valid strobe
//   load_ready             : registered, high when the holding register is empty
//   a_out, a_valid         : serial bit and its qualifier (a_out=0 when not valid)
//   word_done              : one-cycle pulse in the cycle after a word's final bit
//   busy                   : FSM not idle or a word is held
module moore_bit_serializer
    import moore_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int GAP_CYCLES = DEFAULT_GAP_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             a_out,
    output logic             a_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int            CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);
    localparam logic [3:0]    GAP_LAST = 4'(GAP_CYCLES);

    ser_state_t       r_state;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_cnt;
    logic [3:0]       r_gap;
    logic             r_a_out;
    logic             r_a_valid;
    logic             r_word_done;
    logic             r_busy;
`ifdef MOORE_SER_PARITY_EN
    logic             r_par;
`endif

    logic             w_ready;
    logic             w_hold_full;
    logic             w_full_next;
    logic [WIDTH-1:0] w_hold_data;
    logic             w_accept;
    logic             w_push;
    logic             w_pop;
    logic             w_tail;
    logic             w_word_end;
    logic             w_start_new;
    logic             w_start;
    logic             w_to_idle;
    logic [WIDTH-1:0] w_src;

    moore_ser_hold #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_data      (data_in),
        .o_data      (w_hold_data),
        .o_full      (w_hold_full),
        .o_full_next (w_full_next),
        .o_ready     (w_ready)
    );

    assign w_accept = load_valid & w_ready;

    // w_tail: the final valid bit of the word is on a_out this cycle.
`ifdef MOORE_SER_PARITY_EN
    assign w_tail = (r_state == S_PARITY);
`else
    assign w_tail = (r_state == S_SHIFT) && (r_cnt == CNT_LAST);
`endif

    // w_word_end: the last cycle the current word owns (tail, or last gap cycle).
    assign w_word_end = (GAP_CYCLES == 0) ? w_tail
                                          : ((r_state == S_GAP) && (r_gap == GAP_LAST));

    // A held word always wins the shifter; new words only bypass the hold when idle.
    assign w_pop       = w_hold_full & ((r_state == S_IDLE) | w_word_end);
    assign w_start_new = (r_state == S_IDLE) & ~w_hold_full & w_accept;
    assign w_start     = w_pop | w_start_new;
    assign w_push      = w_accept & (r_state != S_IDLE);
    assign w_src       = w_pop ? w_hold_data : data_in;
    assign w_to_idle   = ~w_start & ((r_state == S_IDLE) | w_word_end);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_gap       <= '0;
            r_a_out     <= 1'b0;
            r_a_valid   <= 1'b0;
            r_word_done <= 1'b0;
            r_busy      <= 1'b0;
`ifdef MOORE_SER_PARITY_EN
            r_par       <= 1'b0;
`endif
        end else begin
            r_word_done <= w_tail;
            r_busy      <= ~w_to_idle | w_full_next;
            if (w_start) begin
                // Bit 0 goes straight to the output register; the rest waits in r_shift.
                r_state   <= S_SHIFT;
                r_shift   <= w_src >> 1;
                r_cnt     <= CW'(1);
                r_a_out   <= w_src[0];
                r_a_valid <= 1'b1;
`ifdef MOORE_SER_PARITY_EN
                r_par     <= even_parity(MAX_WIDTH'(w_src));
`endif
            end else begin
                case (r_state)
                    S_SHIFT: begin
                        if (r_cnt != CNT_LAST) begin
                            r_a_out <= r_shift[0];
                            r_shift <= r_shift >> 1;
                            r_cnt   <= r_cnt + 1'b1;
                        end else begin
                            r_cnt <= '0;
`ifdef MOORE_SER_PARITY_EN
                            r_state   <= S_PARITY;
                            r_a_out   <= r_par;
                            r_a_valid <= 1'b1;
`else
                            r_a_out   <= 1'b0;
                            r_a_valid <= 1'b0;
                            if (GAP_CYCLES > 0) begin
                                r_state <= S_GAP;
                                r_gap   <= 4'd1;
                            end else begin
                                r_state <= S_IDLE;
                            end
`endif
                        end
                    end
`ifdef MOORE_SER_PARITY_EN
                    S_PARITY: begin
                        r_a_out   <= 1'b0;
                        r_a_valid <= 1'b0;
                        if (GAP_CYCLES > 0) begin
                            r_state <= S_GAP;
                            r_gap   <= 4'd1;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
`endif
                    S_GAP: begin
                        r_a_out   <= 1'b0;
                        r_a_valid <= 1'b0;
                        if (r_gap == GAP_LAST) begin
                            r_state <= S_IDLE;
                            r_gap   <= '0;
                        end else begin
                            r_gap <= r_gap + 1'b1;
                        end
                    end
                    default: begin
                        r_state   <= S_IDLE;
                        r_a_out   <= 1'b0;
                        r_a_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign load_ready = w_ready;
    assign a_out      = r_a_out;
    assign a_valid    = r_a_valid;
    assign word_done  = r_word_done;
    assign busy       = r_busy;

endmodule

// File: tb/tb_moore_bit_serializer.sv
// tb/tb_moore_bit_serializer.sv - scoreboard bench for moore_bit_serializer (GAP=1 and GAP=0 instances)
module tb_moore_bit_serializer;

    localparam int W = 8;
`ifdef MOORE_SER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int T = W + PAR;

    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    logic         clk   = 1'b0;
    logic         reset = 1'b1;

    logic [W-1:0] ua_data  = '0;
    logic         ua_valid = 1'b0;
    logic         ua_ready, ua_a_out, ua_a_valid, ua_word_done, ua_busy;
    logic [W-1:0] ub_data  = '0;
    logic         ub_valid = 1'b0;
    logic         ub_ready, ub_a_out, ub_a_valid, ub_word_done, ub_busy;

    exp_t qa[$];
    exp_t qb[$];
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   run_a  = 0;
    int   run_b  = 0;
    int   max_b  = 0;
    int   done_b = 0;
    logic dexp_a = 1'b0;
    logic dexp_b = 1'b0;
    logic exp_a5 [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    moore_bit_serializer #(.WIDTH(W), .GAP_CYCLES(1)) u_dut_a (
        .clk(clk), .reset(reset), .data_in(ua_data), .load_valid(ua_valid),
        .load_ready(ua_ready), .a_out(ua_a_out), .a_valid(ua_a_valid),
        .word_done(ua_word_done), .busy(ua_busy)
    );

    moore_bit_serializer #(.WIDTH(W), .GAP_CYCLES(0)) u_dut_b (
        .clk(clk), .reset(reset), .data_in(ub_data), .load_valid(ub_valid),
        .load_ready(ub_ready), .a_out(ub_a_out), .a_valid(ub_a_valid),
        .word_done(ub_word_done), .busy(ub_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: WIDTH data bits LSB first, then an even-parity bit when enabled.
    function automatic exp_t model_bit(input logic [W-1:0] w, input int i);
        exp_t e;
        if (i < W) begin
            e.b    = ((int'(w) >> i) % 2) == 1;
            e.last = (PAR == 0) && (i == W - 1);
        end else begin
            e.b    = ($countones(w) % 2) == 1;
            e.last = 1'b1;
        end
        return e;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_a(input logic [W-1:0] w);
        int t = 0;
        while (!ua_ready && t < 200) begin
            @(posedge clk); #1; t++;
        end
        chk("a_ready_wait", int'(ua_ready), 1);
        ua_data  = w;
        ua_valid = 1'b1;
        @(posedge clk); #1;
        ua_valid = 1'b0;
        for (int i = 0; i < T; i++) qa.push_back(model_bit(w, i));
    endtask

    task automatic send_b(input logic [W-1:0] w);
        int t = 0;
        while (!ub_ready && t < 200) begin
            @(posedge clk); #1; t++;
        end
        chk("b_ready_wait", int'(ub_ready), 1);
        ub_data  = w;
        ub_valid = 1'b1;
        @(posedge clk); #1;
        ub_valid = 1'b0;
        for (int i = 0; i < T; i++) qb.push_back(model_bit(w, i));
    endtask

    task automatic drain();
        int t = 0;
        while ((qa.size() != 0 || qb.size() != 0) && t < 1000) begin
            @(posedge clk); #1; t++;
        end
        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("drain_empty", qa.size() + qb.size(), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            run_a  = 0;
            dexp_a = 1'b0;
        end else begin
            chk("a_word_done", int'(ua_word_done), int'(dexp_a));
            dexp_a = 1'b0;
            if (ua_a_valid) begin
                chk("a_bit_expected", int'(qa.size() > 0), 1);
                if (qa.size() > 0) begin
                    e = qa.pop_front();
                    chk("a_out", int'(ua_a_out), int'(e.b));
                    dexp_a = e.last;
                end
                chk("a_busy", int'(ua_busy), 1);
                run_a++;
            end else begin
                chk("a_out_idle", int'(ua_a_out), 0);
                if (run_a != 0) chk("a_run_len", run_a, T);
                run_a = 0;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            run_b  = 0;
            dexp_b = 1'b0;
        end else begin
            chk("b_word_done", int'(ub_word_done), int'(dexp_b));
            dexp_b = 1'b0;
            if (ub_word_done) done_b++;
            if (ub_a_valid) begin
                chk("b_bit_expected", int'(qb.size() > 0), 1);
                if (qb.size() > 0) begin
                    e = qb.pop_front();
                    chk("b_out", int'(ub_a_out), int'(e.b));
                    dexp_b = e.last;
                end
                run_b++;
            end else begin
                chk("b_out_idle", int'(ub_a_out), 0);
                if (run_b != 0) begin
                    chk("b_run_multiple", run_b % T, 0);
                    if (run_b > max_b) max_b = run_b;
                end
                run_b = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] w;
        int           d0;
        int           nv;
        int           nd;

        // Reset values on both instances.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_ready", int'(ua_ready), 1);
        chk("rst_a_out",   int'(ua_a_out), 0);
        chk("rst_a_valid", int'(ua_a_valid), 0);
        chk("rst_a_done",  int'(ua_word_done), 0);
        chk("rst_a_busy",  int'(ua_busy), 0);
        chk("rst_b_ready", int'(ub_ready), 1);
        chk("rst_b_valid", int'(ub_a_valid), 0);
        chk("rst_b_busy",  int'(ub_busy), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // 8'hA5: bits 1,0,1,0,0,1,0,1 from the cycle after accept, word_done at cycle T.
        send_a(8'hA5);
        for (int k = 0; k <= T; k++) begin
            @(negedge clk);
            if (k < 8) begin
                chk("a5_valid", int'(ua_a_valid), 1);
                chk("a5_bit", int'(ua_a_out), int'(exp_a5[k]));
            end
            if (k == T) begin
                chk("a5_done", int'(ua_word_done), 1);
                chk("a5_gap_valid", int'(ua_a_valid), 0);
            end
        end
        @(posedge clk); #1;
        drain();

`ifdef MOORE_SER_PARITY_EN
        send_a(8'h07);
        send_a(8'h03);
        drain();
`endif

        // 8'h0F then 8'hF0 during SHIFT: hold, one gap cycle, no idle, busy throughout.
        send_a(8'h0F);
        send_a(8'hF0);
        for (int k = 1; k <= 2 * T + 1; k++) begin
            chk("b2b_valid", int'(ua_a_valid), int'((k < T) || (k > T && k <= 2 * T)));
            chk("b2b_ready", int'(ua_ready), int'(k > T));
            chk("b2b_busy",  int'(ua_busy), 1);
            @(posedge clk); #1;
        end
        drain();

        // GAP=0: three back-to-back words form one continuous run.
        max_b = 0;
        d0    = done_b;
        for (int i = 0; i < 3; i++) begin
            w = 8'($urandom);
            send_b(w);
        end
        drain();
        chk("b_cont_run", max_b, 3 * T);
        chk("b_done_cnt", done_b - d0, 3);

        // Reset during bit 4 of 8'hFF with a word held: both discarded.
        send_a(8'hFF);
        send_a(8'h5A);
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("mid_bit4_valid", int'(ua_a_valid), 1);
        chk("mid_hold_ready", int'(ua_ready), 0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_valid", int'(ua_a_valid), 0);
        chk("mid_rst_ready", int'(ua_ready), 1);
        chk("mid_rst_done",  int'(ua_word_done), 0);
        chk("mid_rst_busy",  int'(ua_busy), 0);
        qa.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        nv = 0;
        nd = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (ua_a_valid) nv++;
            if (ua_word_done) nd++;
        end
        chk("mid_no_bits", nv, 0);
        chk("mid_no_done", nd, 0);
        @(posedge clk); #1;

        // load_valid held through reset: accept only on the first edge after release.
        reset    = 1'b1;
        ua_valid = 1'b1;
        ua_data  = 8'h3C;
        repeat (3) begin
            @(posedge clk); #1;
            chk("rv_valid", int'(ua_a_valid), 0);
            chk("rv_ready", int'(ua_ready), 1);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        ua_valid = 1'b0;
        for (int i = 0; i < T; i++) qa.push_back(model_bit(8'h3C, i));
        chk("rv_accept", int'(ua_a_valid), 1);
        drain();

        // Randomised traffic on both instances.
        for (int n = 0; n < 20; n++) begin
            repeat ($urandom_range(0, 12)) begin
                @(posedge clk); #1;
            end
            w = 8'($urandom);
            send_a(w);
        end
        for (int n = 0; n < 15; n++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
            w = 8'($urandom);
            send_b(w);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
